// File: rtl/fpu_arbiter.sv
// fpu_arbiter: round-robin two-requester sequencer for one shared FPUnit; FPU_ARB_TIMEOUT_EN adds a BUSY abort
module fpu_arbiter #(
  parameter int WIDTH = 32,
  parameter int TIMEOUT = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [1:0]       req_op0,
  input  logic [1:0]       req_op1,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_b1,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic [WIDTH-1:0] fpu_a,
  output logic [WIDTH-1:0] fpu_b,
  output logic [1:0]       fpu_opcode,
  output logic             fpu_start,
  input  logic [WIDTH-1:0] fpu_s,
  input  logic             fpu_done,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t state_q, state_d;
  logic prio_q, prio_d, grant_q, grant_d, start_q, start_d, err_q, err_d;
  logic pick, take, fin, rsp_done, tmo;
  logic [1:0] rv_q, rv_d, op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, data_q, data_d;
`ifdef FPU_ARB_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  assign tmo = cnt_q == 16'(TIMEOUT - 1);
  assign cnt_d = take ? 16'd0 : state_q == BUSY ? cnt_q + 16'd1 : cnt_q;
`else
  assign tmo = 1'b0;
`endif
  assign pick = &req_valid ? prio_q : req_valid[1];
  assign take = state_q == IDLE && |req_valid && !fpu_done && !rst;
  assign fin = state_q == BUSY && (fpu_done || tmo);
  assign rsp_done = state_q == RESP && rsp_ready[grant_q];
  assign req_ready = take ? (pick ? 2'b10 : 2'b01) : 2'b00;
  always_comb begin
    state_d = take ? BUSY : fin ? RESP : rsp_done ? IDLE : state_q;
    grant_d = take ? pick : grant_q;
    a_d = take ? (pick ? req_a1 : req_a0) : a_q;
    b_d = take ? (pick ? req_b1 : req_b0) : b_q;
    op_d = take ? (pick ? req_op1 : req_op0) : op_q;
    start_d = take | (start_q & ~fin);
    data_d = fin ? (fpu_done ? fpu_s : '0) : data_q;
    err_d = fin ? ~fpu_done : err_q;
    rv_d = fin ? (grant_q ? 2'b10 : 2'b01) : rsp_done ? 2'b00 : rv_q;
    prio_d = rsp_done ? ~grant_q : prio_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      prio_q <= 1'b0;
      grant_q <= 1'b0;
      start_q <= 1'b0;
      err_q <= 1'b0;
      rv_q <= 2'b00;
      op_q <= 2'b00;
      a_q <= '0;
      b_q <= '0;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      prio_q <= prio_d;
      grant_q <= grant_d;
      start_q <= start_d;
      err_q <= err_d;
      rv_q <= rv_d;
      op_q <= op_d;
      a_q <= a_d;
      b_q <= b_d;
      data_q <= data_d;
    end
  end
`ifdef FPU_ARB_TIMEOUT_EN
  always_ff @(posedge clk) cnt_q <= rst ? 16'd0 : cnt_d;
`endif
  assign rsp_valid = rv_q;
  assign rsp_data = data_q;
  assign rsp_err = err_q;
  assign fpu_a = a_q;
  assign fpu_b = b_q;
  assign fpu_opcode = op_q;
  assign fpu_start = start_q;
  assign busy = state_q != IDLE;
endmodule

// File: tb/tb_fpu_arbiter.sv
// tb_fpu_arbiter: directed table, corner sequences and random traffic against a transaction-level arbiter model
module tb_fpu_arbiter;
  localparam int W = 32;
  localparam int TMO = 16;
  logic clk = 1'b0, rst = 1'b1;
  logic [1:0] req_valid = 2'b00, req_ready, req_op0 = 2'b00, req_op1 = 2'b00;
  logic [1:0] rsp_valid, rsp_ready = 2'b00, fpu_opcode;
  logic [W-1:0] req_a0 = '0, req_a1 = '0, req_b0 = '0, req_b1 = '0;
  logic [W-1:0] rsp_data, fpu_a, fpu_b, fpu_s = '0;
  logic rsp_err, fpu_start, fpu_done = 1'b0, busy;
  int checks = 0, errors = 0;
  int lat = 2, stale_n = 0, f_cyc = 0, f_stale = 0;
  bit never = 1'b0;
  bit m_busy = 1'b0, m_res = 1'b0, m_req = 1'b0, m_prio = 1'b0, e_start = 1'b0, e_err = 1'b0;
  logic [1:0] m_op = 2'b00, e_rv = 2'b00, er, last_ready = 2'b00;
  logic [31:0] m_a = '0, m_b = '0, e_data = '0;
  int m_cnt = 0, resp_count = 0, n;
  int grants[$];
  typedef struct {
    bit req;
    logic [1:0] op;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0] exp_ready;
    logic [31:0] exp_data;
  } vec_t;
  vec_t tbl[4];
  always #5 clk = ~clk;
  fpu_arbiter #(.WIDTH(W), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op0(req_op0), .req_op1(req_op1), .req_a0(req_a0), .req_a1(req_a1),
    .req_b0(req_b0), .req_b1(req_b1), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .fpu_a(fpu_a), .fpu_b(fpu_b),
    .fpu_opcode(fpu_opcode), .fpu_start(fpu_start), .fpu_s(fpu_s), .fpu_done(fpu_done),
    .busy(busy)
  );
  function automatic logic [31:0] fn(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    return (op == 2'b10 && a == 32'h42780000 && b == 32'h43790000) ? 32'h46713800 : a + b + 32'(op);
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic cycle();
    if (f_stale > 0) begin
      fpu_done = 1'b1;
      f_stale--;
    end else if (fpu_start && !never) begin
      f_cyc++;
      fpu_done = f_cyc >= lat;
      if (fpu_done) begin
        fpu_s = fn(fpu_a, fpu_b, fpu_opcode);
        f_stale = stale_n;
        f_cyc = 0;
      end
    end else begin
      fpu_done = 1'b0;
      f_cyc = 0;
    end
    #1;
    er = (rst || m_busy || fpu_done || req_valid == 2'b00) ? 2'b00 :
         req_valid == 2'b11 ? (m_prio ? 2'b10 : 2'b01) : req_valid;
    last_ready = req_ready;
    chk("req_ready", req_ready, er);
    chk("busy", busy, m_busy);
    chk("fpu_start", fpu_start, e_start);
    chk("fpu_a", fpu_a, m_a);
    chk("fpu_b", fpu_b, m_b);
    chk("fpu_opcode", fpu_opcode, m_op);
    chk("rsp_valid", rsp_valid, e_rv);
    chk("rsp_data", rsp_data, e_data);
    chk("rsp_err", rsp_err, e_err);
    if (!rst && (req_ready & req_valid) != 2'b00) grants.push_back(int'(req_ready[1]));
    if (!rst && (rsp_valid & rsp_ready) != 2'b00) resp_count++;
    if (rst) begin
      m_busy = 0; m_res = 0; m_prio = 0; m_a = '0; m_b = '0; m_op = 2'b00;
      e_start = 0; e_rv = 2'b00; e_data = '0; e_err = 0;
    end else if (!m_busy) begin
      if (er != 2'b00) begin
        m_req = er[1];
        m_a = m_req ? req_a1 : req_a0;
        m_b = m_req ? req_b1 : req_b0;
        m_op = m_req ? req_op1 : req_op0;
        m_busy = 1; e_start = 1; m_cnt = 0;
      end
    end else if (!m_res) begin
      if (fpu_done) begin
        m_res = 1; e_rv = m_req ? 2'b10 : 2'b01; e_data = fn(m_a, m_b, m_op); e_err = 0; e_start = 0;
      end
`ifdef FPU_ARB_TIMEOUT_EN
      else if (m_cnt == TMO - 1) begin
        m_res = 1; e_rv = m_req ? 2'b10 : 2'b01; e_data = '0; e_err = 1; e_start = 0;
      end else m_cnt++;
`endif
    end else if (rsp_ready[m_req]) begin
      m_busy = 0; m_res = 0; e_rv = 2'b00; m_prio = !m_req;
    end
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask
  initial begin
    tbl[0] = '{1'b0, 2'b10, 32'h42780000, 32'h43790000, 2'b01, 32'h46713800};
    tbl[1] = '{1'b1, 2'b01, 32'h0000000a, 32'h00000014, 2'b10, 32'h0000001f};
    tbl[2] = '{1'b1, 2'b11, 32'hffffffff, 32'h00000001, 2'b10, 32'h00000003};
    tbl[3] = '{1'b0, 2'b00, 32'h00000064, 32'h00000000, 2'b01, 32'h00000064};
    @(negedge clk);
    cycle();
    cycle();
    rst = 1'b0;
    rsp_ready = 2'b11;
    for (int i = 0; i < 4; i++) begin
      req_a0 = $urandom; req_a1 = $urandom; req_b0 = $urandom; req_b1 = $urandom;
      req_op0 = 2'($urandom); req_op1 = 2'($urandom);
      if (tbl[i].req) begin
        req_op1 = tbl[i].op; req_a1 = tbl[i].a; req_b1 = tbl[i].b;
      end else begin
        req_op0 = tbl[i].op; req_a0 = tbl[i].a; req_b0 = tbl[i].b;
      end
      req_valid = tbl[i].req ? 2'b10 : 2'b01;
      lat = 1 + i;
      cycle();
      chk("tbl_ready", last_ready, tbl[i].exp_ready);
      req_valid = 2'b00;
      req_a0 = $urandom; req_a1 = $urandom; req_b0 = $urandom; req_b1 = $urandom;
      n = 0;
      while (rsp_valid == 2'b00 && n < 20) begin
        cycle();
        n++;
      end
      chk("tbl_rsp_valid", rsp_valid, tbl[i].exp_ready);
      chk("tbl_rsp_data", rsp_data, tbl[i].exp_data);
      cycle();
    end
    do_reset();
    lat = 2;
    grants.delete();
    req_valid = 2'b11;
    n = 0;
    while (grants.size() < 4 && n < 100) begin
      cycle();
      n++;
    end
    chk("contention_count", 32'(grants.size()), 32'd4);
    for (int i = 0; i < 4 && i < grants.size(); i++) chk("contention_grant", 32'(grants[i]), 32'(i % 2));
    do_reset();
    grants.delete();
    rsp_ready = 2'b10;
    n = 0;
    while (rsp_valid == 2'b00 && n < 20) begin
      cycle();
      n++;
    end
    chk("bp_first", rsp_valid, 2'b01);
    for (int i = 0; i < 20; i++) cycle();
    chk("bp_hold", rsp_valid, 2'b01);
    chk("bp_grants", 32'(grants.size()), 32'd1);
    rsp_ready = 2'b11;
    cycle();
    n = 0;
    while (grants.size() < 2 && n < 20) begin
      cycle();
      n++;
    end
    chk("bp_next_grant", grants.size() >= 2 ? 32'(grants[1]) : 32'hdead, 32'd1);
    do_reset();
    req_valid = 2'b00;
    cycle();
    lat = 30;
    req_valid = 2'b01;
    cycle();
    req_valid = 2'b00;
    for (int i = 0; i < 4; i++) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("rst_fpu_start", fpu_start, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 2'b00);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (rsp_valid != 2'b00) n++;
    end
    chk("rst_no_rsp", 32'(n), 32'd0);
    lat = 2;
    stale_n = 3;
    grants.delete();
    resp_count = 0;
    req_valid = 2'b11;
    for (int i = 0; i < 30; i++) cycle();
    req_valid = 2'b00;
    for (int i = 0; i < 10; i++) cycle();
    chk("stale_rsp_count", 32'(resp_count), 32'(grants.size()));
    stale_n = 0;
`ifdef FPU_ARB_TIMEOUT_EN
    do_reset();
    never = 1'b1;
    rsp_ready = 2'b00;
    req_valid = 2'b01;
    cycle();
    req_valid = 2'b00;
    n = 0;
    while (rsp_valid == 2'b00 && n < 40) begin
      cycle();
      n++;
    end
    chk("tmo_cycles", 32'(n), 32'd16);
    chk("tmo_err", rsp_err, 1'b1);
    chk("tmo_data", rsp_data, 32'd0);
    rsp_ready = 2'b11;
    cycle();
    never = 1'b0;
`endif
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      req_valid = 2'($urandom);
      req_a0 = $urandom; req_a1 = $urandom; req_b0 = $urandom; req_b1 = $urandom;
      req_op0 = 2'($urandom); req_op1 = 2'($urandom);
      rsp_ready = 2'($urandom);
      rst = $urandom_range(299) == 0;
      if (!fpu_start) begin
        lat = 1 + int'($urandom_range(4));
        stale_n = int'($urandom_range(2));
      end
      cycle();
    end
    rst = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
